// File: rtl/vend_txn_ctrl.sv
// Vending machine transaction controller: debounces touch area codes into single
// key events and runs the purchase FSM (selection, credit, dispense, change, refund).
module vend_txn_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int PRICE_ROW1 = 5,
    parameter int PRICE_ROW2 = 8,
    parameter int PRICE_ROW3 = 12,
    parameter int CREDIT_MAX = 100
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] area_flag,
    output logic       key_pulse,
    output logic [4:0] key_code,
    output logic [2:0] state,
    output logic [3:0] sel_item,
    output logic [7:0] credit,
    output logic       dispense_valid,
    output logic [3:0] dispense_item,
    output logic       change_valid,
    output logic [7:0] change_amt,
    output logic       err_pulse
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_CNT    = CW'(DEB_CYCLES);
    localparam logic [8:0]    CREDIT_LIM = 9'(CREDIT_MAX);

    localparam logic [4:0] KEY_HALF     = 5'd13;
    localparam logic [4:0] KEY_ONE      = 5'd14;
    localparam logic [4:0] KEY_FIVE     = 5'd15;
    localparam logic [4:0] KEY_WITHDRAW = 5'd16;
    localparam logic [4:0] KEY_CONFIRM  = 5'd17;
    localparam logic [4:0] KEY_CANCEL   = 5'd18;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SELECTED = 3'd1,
        S_DISPENSE = 3'd2,
        S_CHANGE   = 3'd3,
        S_REFUND   = 3'd4
    } state_t;

    // ---------------------------------------------------------------- debouncer
    logic [4:0]    sample;
    logic [4:0]    prev_q;
    logic [CW-1:0] run_q, run_d;
    logic          armed_q, armed_d;
    logic          key_pulse_q, key_pulse_d;
    logic [4:0]    key_code_q, key_code_d;

    // Codes above CANCEL are unused by the area judge and behave like "no touch".
    always_comb sample = (area_flag > KEY_CANCEL) ? 5'd0 : area_flag;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        run_d       = run_q;
        armed_d     = armed_q;
        key_pulse_d = 1'b0;
        key_code_d  = 5'd0;
        if (sample != prev_q) begin
            run_d = CW'(1);
        end else if (run_q != DEB_CNT) begin
            run_d = run_q + CW'(1);
        end
        if (run_d == DEB_CNT) begin
            if (sample == 5'd0) begin
                armed_d = 1'b1;
            end else if (armed_q) begin
                key_pulse_d = 1'b1;
                key_code_d  = sample;
                armed_d     = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- purchase FSM
    state_t     state_q, state_d;
    state_t     ret_q, ret_d;
    logic [3:0] sel_q, sel_d;
    logic [7:0] credit_q, credit_d;
    logic       dv_q, dv_d;
    logic [3:0] di_q, di_d;
    logic       cv_q, cv_d;
    logic [7:0] ca_q, ca_d;
    logic       err_q, err_d;

    logic [8:0] coin_sum;
    logic [7:0] price;
    logic [7:0] remain;

    function automatic logic [7:0] price_of(input logic [3:0] item);
        if (item <= 4'd4)      return 8'(PRICE_ROW1);
        else if (item <= 4'd8) return 8'(PRICE_ROW2);
        else                   return 8'(PRICE_ROW3);
    endfunction

    function automatic logic [7:0] coin_value(input logic [4:0] code);
        case (code)
            KEY_HALF: return 8'd1;
            KEY_ONE:  return 8'd2;
            KEY_FIVE: return 8'd10;
            default:  return 8'd0;
        endcase
    endfunction

    always_comb begin
        coin_sum = {1'b0, credit_q} + {1'b0, coin_value(key_code_q)};
        price    = price_of(sel_q);
        remain   = credit_q - price;
    end

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        sel_d    = sel_q;
        credit_d = credit_q;
        dv_d     = 1'b0;
        di_d     = 4'd0;
        cv_d     = 1'b0;
        ca_d     = 8'd0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE, S_SELECTED: begin
                if (key_pulse_q) begin
                    case (key_code_q) inside
                        [5'd1:5'd12]: begin
                            sel_d   = key_code_q[3:0];
                            state_d = S_SELECTED;
                        end
                        KEY_HALF, KEY_ONE, KEY_FIVE: begin
                            if (coin_sum <= CREDIT_LIM) credit_d = coin_sum[7:0];
                            else                        err_d    = 1'b1;
                        end
                        KEY_WITHDRAW: begin
                            if (credit_q != 8'd0) begin
                                state_d = S_REFUND;
                                ret_d   = state_q;
                                cv_d    = 1'b1;
                                ca_d    = credit_q;
                            end
                        end
                        KEY_CONFIRM: begin
                            if (state_q == S_SELECTED) begin
                                if (credit_q >= price) begin
                                    state_d = S_DISPENSE;
                                    dv_d    = 1'b1;
                                    di_d    = sel_q;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                        end
                        KEY_CANCEL: begin
                            state_d = S_REFUND;
                            ret_d   = S_IDLE;
                            sel_d   = 4'd0;
                            cv_d    = (credit_q != 8'd0);
                            ca_d    = credit_q;
                        end
                        default: ;
                    endcase
                end
            end
            S_DISPENSE: begin
                // Change strobe is registered here so it lines up with the CHANGE cycle.
                credit_d = remain;
                state_d  = S_CHANGE;
                cv_d     = (remain != 8'd0);
                ca_d     = remain;
            end
            S_CHANGE: begin
                credit_d = 8'd0;
                sel_d    = 4'd0;
                state_d  = S_IDLE;
            end
            S_REFUND: begin
                credit_d = 8'd0;
                state_d  = ret_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_q      <= 5'd0;
            run_q       <= '0;
            armed_q     <= 1'b1;
            key_pulse_q <= 1'b0;
            key_code_q  <= 5'd0;
            state_q     <= S_IDLE;
            ret_q       <= S_IDLE;
            sel_q       <= 4'd0;
            credit_q    <= 8'd0;
            dv_q        <= 1'b0;
            di_q        <= 4'd0;
            cv_q        <= 1'b0;
            ca_q        <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            prev_q      <= sample;
            run_q       <= run_d;
            armed_q     <= armed_d;
            key_pulse_q <= key_pulse_d;
            key_code_q  <= key_code_d;
            state_q     <= state_d;
            ret_q       <= ret_d;
            sel_q       <= sel_d;
            credit_q    <= credit_d;
            dv_q        <= dv_d;
            di_q        <= di_d;
            cv_q        <= cv_d;
            ca_q        <= ca_d;
            err_q       <= err_d;
        end
    end

    assign key_pulse      = key_pulse_q;
    assign key_code       = key_code_q;
    assign state          = state_q;
    assign sel_item       = sel_q;
    assign credit         = credit_q;
    assign dispense_valid = dv_q;
    assign dispense_item  = di_q;
    assign change_valid   = cv_q;
    assign change_amt     = ca_q;
    assign err_pulse      = err_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Self-checking bench for vend_txn_ctrl: directed scenarios plus random key traffic,
// compared every cycle against a timeline-based transaction model.
module tb_vend_txn_ctrl;

    localparam int DEB  = 4;
    localparam int MAXC = 16384;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [4:0] area_flag = 5'd0;
    logic       key_pulse;
    logic [4:0] key_code;
    logic [2:0] state;
    logic [3:0] sel_item;
    logic [7:0] credit;
    logic       dispense_valid;
    logic [3:0] dispense_item;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       err_pulse;

    always #5 clk = ~clk;

    vend_txn_ctrl #(.DEB_CYCLES(DEB)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .area_flag      (area_flag),
        .key_pulse      (key_pulse),
        .key_code       (key_code),
        .state          (state),
        .sel_item       (sel_item),
        .credit         (credit),
        .dispense_valid (dispense_valid),
        .dispense_item  (dispense_item),
        .change_valid   (change_valid),
        .change_amt     (change_amt),
        .err_pulse      (err_pulse)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    // Each slot holds what the outputs must show during one clock period. A key
    // transaction writes the whole outcome into the future slots at once.
    typedef struct {
        int st; int sel; int cr;
        bit dv; int di;
        bit cv; int ca;
        bit err;
    } snap_t;

    snap_t expv [MAXC];
    bit    wr   [MAXC];
    bit    ekp  [MAXC];
    int    ekc  [MAXC];
    int    cur = 0;
    int    prev_v = 0, run = 0;
    bit    armed = 1'b1;

    function automatic snap_t mk(input int st, input int sel, input int cr);
        snap_t s;
        s.st = st; s.sel = sel; s.cr = cr;
        s.dv = 1'b0; s.di = 0; s.cv = 1'b0; s.ca = 0; s.err = 1'b0;
        return s;
    endfunction

    function automatic int price_of(input int item);
        return (item <= 4) ? 5 : ((item <= 8) ? 8 : 12);
    endfunction

    function automatic void put(input int slot, input snap_t s);
        expv[slot] = s;
        wr[slot]   = 1'b1;
    endfunction

    function automatic void apply_key(input int code, input int k);
        snap_t b;
        snap_t s;
        int v, p;
        b = expv[k];
        if (code >= 1 && code <= 12) begin
            put(k + 1, mk(1, code, b.cr));
        end else if (code >= 13 && code <= 15) begin
            v = (code == 13) ? 1 : ((code == 14) ? 2 : 10);
            if (b.cr + v <= 100) put(k + 1, mk(b.st, b.sel, b.cr + v));
            else begin s = mk(b.st, b.sel, b.cr); s.err = 1'b1; put(k + 1, s); end
        end else if (code == 17 && b.st == 1) begin
            p = price_of(b.sel);
            if (b.cr >= p) begin
                s = mk(2, b.sel, b.cr); s.dv = 1'b1; s.di = b.sel; put(k + 1, s);
                s = mk(3, b.sel, b.cr - p); s.cv = (b.cr - p) != 0; s.ca = b.cr - p; put(k + 2, s);
                put(k + 3, mk(0, 0, 0));
            end else begin
                s = mk(1, b.sel, b.cr); s.err = 1'b1; put(k + 1, s);
            end
        end else if (code == 16 && b.cr != 0) begin
            s = mk(4, b.sel, b.cr); s.cv = 1'b1; s.ca = b.cr; put(k + 1, s);
            put(k + 2, mk(b.st, b.sel, 0));
        end else if (code == 18) begin
            s = mk(4, 0, b.cr); s.cv = b.cr != 0; s.ca = b.cr; put(k + 1, s);
            put(k + 2, mk(0, 0, 0));
        end
    endfunction

    initial begin
        int n, v;
        expv[0] = mk(0, 0, 0);
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                prev_v = 0; run = 0; armed = 1'b1;
                expv[cur] = mk(0, 0, 0);
                ekp[cur] = 1'b0; ekc[cur] = 0;
                for (int i = 1; i <= 4; i++) wr[cur + i] = 1'b0;
            end else begin
                n = cur + 1;
                if (ekp[cur] && expv[cur].st <= 1) apply_key(ekc[cur], cur);
                if (!wr[n]) expv[n] = mk(expv[cur].st, expv[cur].sel, expv[cur].cr);
                v = int'(area_flag);
                if (v > 18) v = 0;
                run = (v == prev_v) ? run + 1 : 1;
                prev_v = v;
                ekp[n] = 1'b0; ekc[n] = 0;
                if (v != 0 && run == DEB && armed) begin
                    ekp[n] = 1'b1; ekc[n] = v; armed = 1'b0;
                end else if (v == 0 && run >= DEB) begin
                    armed = 1'b1;
                end
                cur = n;
            end
        end
    end

    // ---------------------------------------------------------------- compare + event counters
    int kp_cnt = 0, dv_cnt = 0, cv_cnt = 0, err_cnt = 0;
    int last_kc = 0, last_di = 0, last_ca = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                check("key_pulse", int'(key_pulse), int'(ekp[cur]));
                if (ekp[cur]) check("key_code", int'(key_code), ekc[cur]);
                check("state", int'(state), expv[cur].st);
                check("sel_item", int'(sel_item), expv[cur].sel);
                check("credit", int'(credit), expv[cur].cr);
                check("dispense_valid", int'(dispense_valid), int'(expv[cur].dv));
                if (expv[cur].dv) check("dispense_item", int'(dispense_item), expv[cur].di);
                check("change_valid", int'(change_valid), int'(expv[cur].cv));
                if (expv[cur].cv) check("change_amt", int'(change_amt), expv[cur].ca);
                check("err_pulse", int'(err_pulse), int'(expv[cur].err));
                if (key_pulse)      begin kp_cnt++; last_kc = int'(key_code); end
                if (dispense_valid) begin dv_cnt++; last_di = int'(dispense_item); end
                if (change_valid)   begin cv_cnt++; last_ca = int'(change_amt); end
                if (err_pulse)      err_cnt++;
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic hold(input int v, input int n);
        area_flag = 5'(v);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input int v);
        hold(v, DEB + 2);
        hold(0, DEB + 2);
    endtask

    initial begin
        int k0, d0, c0, e0, code, r;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        check("rst_state", int'(state), 0);
        check("rst_credit", int'(credit), 0);
        check("rst_sel", int'(sel_item), 0);
        check("rst_key_pulse", int'(key_pulse), 0);
        hold(0, DEB + 1);

        k0 = kp_cnt; hold(7, DEB - 1); hold(0, DEB + 2);
        check("short_press_ignored", kp_cnt - k0, 0);
        k0 = kp_cnt; hold(7, 10); hold(0, DEB + 2);
        check("long_press_once", kp_cnt - k0, 1);
        check("long_press_code", last_kc, 7);

        press(2); repeat (3) press(14);
        check("buy2_credit", int'(credit), 6);
        d0 = dv_cnt; c0 = cv_cnt; press(17);
        check("buy2_dispense", dv_cnt - d0, 1);
        check("buy2_item", last_di, 2);
        check("buy2_change", cv_cnt - c0, 1);
        check("buy2_change_amt", last_ca, 1);
        check("buy2_idle", int'(state), 0);
        check("buy2_credit0", int'(credit), 0);

        press(9); press(15);
        e0 = err_cnt; press(17);
        check("short_credit_err", err_cnt - e0, 1);
        check("short_credit_state", int'(state), 1);
        check("short_credit_credit", int'(credit), 10);
        press(14);
        d0 = dv_cnt; c0 = cv_cnt; press(17);
        check("exact_dispense", dv_cnt - d0, 1);
        check("exact_item", last_di, 9);
        check("exact_no_change", cv_cnt - c0, 0);

        repeat (9) press(15); repeat (2) press(14); press(13);
        check("ceil_credit95", int'(credit), 95);
        e0 = err_cnt; press(15);
        check("ceil_err", err_cnt - e0, 1);
        check("ceil_hold95", int'(credit), 95);
        press(14);
        check("ceil_credit97", int'(credit), 97);
        press(16);
        check("ceil_refund", last_ca, 97);

        press(5); repeat (2) press(14); press(16);
        check("withdraw_amt", last_ca, 4);
        check("withdraw_state", int'(state), 1);
        check("withdraw_sel", int'(sel_item), 5);
        c0 = cv_cnt; press(18);
        check("cancel_no_change", cv_cnt - c0, 0);
        check("cancel_state", int'(state), 0);
        check("cancel_sel", int'(sel_item), 0);

        press(3); repeat (2) press(15);
        check("pre_rst_credit", int'(credit), 20);
        area_flag = 5'd13;
        #1 rstn = 1'b0;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_credit", int'(credit), 0);
        check("async_rst_sel", int'(sel_item), 0);
        check("async_rst_change", int'(change_valid), 0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        k0 = kp_cnt;
        repeat (DEB - 1) @(posedge clk);
        #2;
        check("post_rst_no_early_key", kp_cnt - k0, 0);
        repeat (2) @(posedge clk);
        #2;
        check("post_rst_key", kp_cnt - k0, 1);
        check("post_rst_code", last_kc, 13);
        hold(0, DEB + 2);
        check("post_rst_credit", int'(credit), 1);

        for (int i = 0; i < 250 && cur < MAXC - 200; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 6)       code = int'($urandom_range(1, 12));
            else if (r < 12) code = int'($urandom_range(13, 15));
            else if (r < 14) code = 17;
            else if (r == 14) code = 16;
            else if (r == 15) code = 18;
            else if (r == 16) code = int'($urandom_range(19, 31));
            else             code = 15;
            if ($urandom_range(0, 5) == 0) hold(code, int'($urandom_range(1, DEB - 1)));
            else                           hold(code, DEB + int'($urandom_range(0, 4)));
            if ($urandom_range(0, 7) == 0) hold(0, int'($urandom_range(1, DEB - 1)));
            else                           hold(0, DEB + int'($urandom_range(0, 3)));
        end
        hold(0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vend_txn_ctrl.md
# vend_txn_ctrl

Transaction controller for the touchscreen vending machine. Consumes the 5-bit touch area code from the area judge stage, debounces it into single key events, and runs the purchase state machine. The state machine tracks item selection and coin credit in half-yuan units, and issues dispense and change/refund pulses to the motor and coin-return drivers and to the display.

## Interface
- DEB_CYCLES, 16: consecutive identical samples needed to accept a press; also the number of zero samples needed to re-arm.
- PRICE_ROW1, 5: price of items 1-4, in half-yuan units.
- PRICE_ROW2, 8: price of items 5-8, in half-yuan units.
- PRICE_ROW3, 12: price of items 9-12, in half-yuan units.
- CREDIT_MAX, 100: credit ceiling, in half-yuan units.

- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- area_flag  in  5  area code: 0 none, 1-12 item, 13 half yuan, 14 one yuan, 15 five yuan, 16 withdraw, 17 confirm, 18 cancel; 19-31 treated as 0
- key_pulse  out  1  one-cycle accepted-key strobe
- key_code  out  5  code of the accepted key; valid with key_pulse
- state  out  3  IDLE=0, SELECTED=1, DISPENSE=2, CHANGE=3, REFUND=4
- sel_item  out  4  selected item 1-12; 0 means none
- credit  out  8  inserted credit, in half-yuan units
- dispense_valid  out  1  one-cycle dispense strobe
- dispense_item  out  4  item to dispense; valid with dispense_valid
- change_valid  out  1  one-cycle coin-return strobe
- change_amt  out  8  amount to return, in half-yuan units; valid with change_valid
- err_pulse  out  1  one-cycle strobe: insufficient credit, or a coin rejected by the ceiling

## Operation
- Reset values: all outputs 0; state IDLE; debouncer armed; run counter 0.
- Debouncer:
  - A counter counts consecutive edges with the same nonzero area_flag. A change of value restarts the count at 1.
  - When the count reaches DEB_CYCLES while armed: key_pulse=1 and key_code=value for exactly one cycle, and the debouncer disarms.
  - Holding a key never repeats it.
  - Re-arm requires area_flag==0 on DEB_CYCLES consecutive edges. A press shorter than DEB_CYCLES is ignored.
- Price lookup: rows 1/2/3 map to PRICE_ROW1/2/3. Widths are 8-bit unsigned.
- Coin keys (13/14/15 add 1/2/10) in IDLE or SELECTED:
  - If credit + value <= CREDIT_MAX, credit increases by value.
  - Otherwise credit is unchanged and err_pulse fires.
- Item key (1-12):
  - In IDLE: latch sel_item and go to SELECTED.
  - In SELECTED: replace sel_item.
- CONFIRM:
  - In SELECTED with credit >= price: go to DISPENSE.
  - In SELECTED with credit < price: err_pulse, stay in SELECTED.
  - In IDLE: ignored.
- DISPENSE (1 cycle): dispense_valid=1, dispense_item=sel_item; credit <= credit - price; go to CHANGE.
- CHANGE (1 cycle):
  - If credit != 0: change_valid=1, change_amt=credit.
  - Then credit=0, sel_item=0, go to IDLE.
- WITHDRAW in IDLE or SELECTED:
  - With credit != 0: go to REFUND. REFUND (1 cycle): change_valid, change_amt=credit; credit=0; return to the prior state (sel_item kept).
  - With credit == 0: no action.
- CANCEL in IDLE or SELECTED:
  - Go to REFUND and clear sel_item; afterwards go to IDLE.
  - No change_valid if credit == 0.
- Keys accepted while in DISPENSE, CHANGE or REFUND are dropped.
- rstn assertion mid-transaction clears credit with no change pulse. Recovering that credit is a software/operator concern.

## Timing
- Press accepted on edge N (the DEB_CYCLES-th identical sample). key_pulse is high in the cycle after edge N.
- The FSM reacts on the next edge, so state, credit and sel_item update one cycle after key_pulse.
- err_pulse is asserted in that same reacting cycle.
- CONFIRM with enough credit gives this sequence:
  - key_pulse cycle k
  - DISPENSE with dispense_valid in cycle k+1
  - CHANGE with change_valid in cycle k+2
  - IDLE in cycle k+3
- All outputs are registered; no combinational path from area_flag.

## Test plan
- Run DEB_CYCLES=4. Hold area_flag=7 for 3 cycles then 0: no key_pulse. Hold 7 for 10 cycles: exactly one key_pulse, key_code=7.
- Select item 2, insert one yuan ×3 (credit=6), CONFIRM:
  - dispense_valid with item 2
  - next cycle change_valid with amt 1
  - then IDLE, credit=0
- Select item 9, insert five yuan (credit=10), CONFIRM: err_pulse, stay in SELECTED with credit=10. Add one yuan, CONFIRM: dispense, no change_valid.
- With credit 95, insert five yuan: err_pulse, credit 95. Then insert one yuan: credit 97.
- Select item 5, credit 4, WITHDRAW: change_amt=4, state SELECTED, sel_item=5. Then CANCEL: no change_valid, IDLE, sel_item=0.
- Deassert rstn while in SELECTED with credit 20: all outputs return to 0 immediately. Key 13 held across the reset release: no key_pulse until it has been held DEB_CYCLES samples after reset.
